// File: rtl/sha256_sched_ctrl.sv
// sha256_sched_ctrl: reads 4 lanes x 16 words from block RAM in lane-interleaved order, feeds the
// expander and merges RAM/expander words into one round/lane-tagged W stream. Perf counters: SHA_SCHED_PERF_EN.
module sha256_sched_ctrl #(
   parameter int RD_LAT = 1,
   parameter int ADDR_W = 6
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [3:0]        lane_en_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] bram_addr_o,
   output logic              bram_en_o,
   input  logic [31:0]       bram_data_i,
   output logic              exp_send_o,
   output logic [31:0]       exp_data_o,
   input  logic [31:0]       exp_w_i,
`ifdef SHA_SCHED_PERF_EN
   output logic [15:0]       perf_batches_o,
   output logic [31:0]       perf_busy_o,
`endif
   output logic              w_valid_o,
   output logic [31:0]       w_o,
   output logic [5:0]        w_round_o,
   output logic [1:0]        w_lane_o,
   output logic              w_lane_en_o
);
   typedef enum logic [2:0] {IDLE, PRIME, FEED, EXPAND, DONE} state_t;
   state_t      state;
   logic [5:0]  r;
   logic [7:0]  t;
   logic [1:0]  p;
   logic [3:0]  mask;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         r          <= '0;
         t          <= '0;
         p          <= '0;
         mask       <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         bram_en_o  <= 1'b0;
         exp_send_o <= 1'b0;
         w_valid_o  <= 1'b0;
      end else begin
         // the read side runs independently of the state so that it may overlap FEED for long RD_LAT
         if (bram_en_o) begin
            r <= r + 6'd1;
            if (r == 6'd63) bram_en_o <= 1'b0;
         end
         case (state)
            IDLE: if (start_i) begin
               state     <= PRIME;
               mask      <= lane_en_i;
               busy_o    <= 1'b1;
               bram_en_o <= 1'b1;
               r         <= '0;
               p         <= '0;
            end
            PRIME: begin
               p <= p + 2'd1;
               if (p == 2'(RD_LAT - 1)) begin
                  state      <= FEED;
                  exp_send_o <= 1'b1;
                  w_valid_o  <= 1'b1;
                  t          <= '0;
               end
            end
            FEED: begin
               t <= t + 8'd1;
               if (t == 8'd63) begin
                  state      <= EXPAND;
                  exp_send_o <= 1'b0;
               end
            end
            EXPAND: begin
               t <= t + 8'd1;
               if (t == 8'd255) begin
                  state     <= DONE;
                  w_valid_o <= 1'b0;
                  busy_o    <= 1'b0;
                  done_o    <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               done_o <= 1'b0;
            end
         endcase
      end
   end
   assign bram_addr_o = ADDR_W'({r[1:0], r[5:2]});
   assign exp_data_o  = exp_send_o ? bram_data_i : '0;
   assign w_o         = !w_valid_o ? '0 : exp_send_o ? bram_data_i : exp_w_i;
   assign w_round_o   = t[7:2];
   assign w_lane_o    = t[1:0];
   assign w_lane_en_o = w_valid_o & mask[t[1:0]];
`ifdef SHA_SCHED_PERF_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_batches_o <= '0;
         perf_busy_o    <= '0;
      end else begin
         perf_batches_o <= perf_batches_o + 16'(done_o);
         perf_busy_o    <= (busy_o && perf_busy_o != '1) ? perf_busy_o + 32'd1 : perf_busy_o;
      end
   end
`endif
endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// tb_sha256_sched_ctrl: randomized bench with a RAM model, a software SHA-256 schedule acting as the
// expander, and a slot-based reference for the whole W stream.
module tb_sha256_sched_ctrl;
   localparam int LAT = 1;
   logic        clk = 1'b0, rst_i = 1'b0, start_i = 1'b0;
   logic [3:0]  lane_en_i = '0;
   logic        busy_o, done_o, bram_en_o, exp_send_o, w_valid_o, w_lane_en_o;
   logic [5:0]  bram_addr_o, w_round_o;
   logic [31:0] bram_data_i, exp_data_o, w_o;
   logic [31:0] exp_w_i = '0;
   logic [1:0]  w_lane_o;
`ifdef SHA_SCHED_PERF_EN
   logic [15:0] perf_batches_o;
   logic [31:0] perf_busy_o;
`endif
   logic [31:0] mem [0:63];
   logic [31:0] sched [0:3][0:63];
   logic [31:0] pipe [0:LAT-1];
   int compared = 0, mismatched = 0;

   sha256_sched_ctrl #(.RD_LAT(LAT), .ADDR_W(6)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .lane_en_i(lane_en_i),
      .busy_o(busy_o), .done_o(done_o), .bram_addr_o(bram_addr_o), .bram_en_o(bram_en_o),
      .bram_data_i(bram_data_i), .exp_send_o(exp_send_o), .exp_data_o(exp_data_o), .exp_w_i(exp_w_i),
`ifdef SHA_SCHED_PERF_EN
      .perf_batches_o(perf_batches_o), .perf_busy_o(perf_busy_o),
`endif
      .w_valid_o(w_valid_o), .w_o(w_o), .w_round_o(w_round_o), .w_lane_o(w_lane_o),
      .w_lane_en_o(w_lane_en_o)
   );

   always #5 clk = ~clk;

   // RAM with LAT-cycle read pipeline; garbage when not enabled
   always @(posedge clk) begin
      pipe[0] <= bram_en_o ? mem[bram_addr_o] : $urandom;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign bram_data_i = pipe[LAT-1];

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic fill_mem(input bit pattern);
      for (int i = 0; i < 64; i++) mem[i] = pattern ? 32'h1000 * (i / 16) + 32'(i % 16) : $urandom;
      for (int l = 0; l < 4; l++)
         for (int k = 0; k < 64; k++)
            if (k < 16) sched[l][k] = mem[l*16+k];
            else sched[l][k] = (ror(sched[l][k-2], 17) ^ ror(sched[l][k-2], 19) ^ (sched[l][k-2] >> 10))
                             + sched[l][k-7]
                             + (ror(sched[l][k-15], 7) ^ ror(sched[l][k-15], 18) ^ (sched[l][k-15] >> 3))
                             + sched[l][k-16];
   endtask

   task automatic check_idle(input string name);
      compared++;
      if ({busy_o, done_o, bram_en_o, exp_send_o, w_valid_o, bram_addr_o, exp_data_o, w_round_o, w_lane_o, w_lane_en_o} !== '0) begin
         mismatched++;
         $display("FAIL %s: busy=%b done=%b en=%b send=%b valid=%b addr=%h xd=%h rnd=%0d ln=%0d le=%b, required all 0",
                  name, busy_o, done_o, bram_en_o, exp_send_o, w_valid_o, bram_addr_o, exp_data_o, w_round_o, w_lane_o, w_lane_en_o);
      end
   endtask

   // One batch from the start cycle (d=0) through DONE; leaves the bench at the first IDLE cycle after DONE.
   task automatic run_batch(input logic [3:0] m, input bit noisy, input int rst_slot);
      int slot, ln, rnd, idx;
      bit e_busy, e_en, e_send, e_val, e_done;
      logic [31:0] e_w;
      start_i = 1'b1;
      lane_en_i = m;
      for (int d = 0; d <= LAT + 257; d++) begin
         slot = d - 1 - LAT;
         if (d > 0) begin
            start_i = noisy && (slot == 10 || slot == 256);
            lane_en_i = 4'($urandom);
         end
         ln = slot & 3;
         rnd = slot >>> 2;
         exp_w_i = $urandom;
         if (slot >= 64 && slot < 256) exp_w_i = sched[ln][rnd];
         if (slot == rst_slot) begin
            rst_i = 1'b1;
            @(negedge clk);
            check_idle("mid_reset");
            @(posedge clk); #1;
            rst_i = 1'b0;
            start_i = 1'b0;
            for (int k = 0; k < 6; k++) begin
               @(negedge clk);
               check_idle("after_reset");
               @(posedge clk); #1;
            end
            return;
         end
         @(negedge clk);
         e_busy = d >= 1 && slot <= 255;
         e_en   = d >= 1 && d <= 64;
         e_send = slot >= 0 && slot <= 63;
         e_val  = slot >= 0 && slot <= 255;
         e_done = slot == 256;
         compared++;
         if ({busy_o, done_o, bram_en_o, exp_send_o, w_valid_o} !== {e_busy, e_done, e_en, e_send, e_val}) begin
            mismatched++;
            $display("FAIL ctl d=%0d: busy/done/en/send/valid=%b%b%b%b%b, required %b%b%b%b%b", d,
                     busy_o, done_o, bram_en_o, exp_send_o, w_valid_o, e_busy, e_done, e_en, e_send, e_val);
         end
         if (e_en) begin
            idx = d - 1;
            compared++;
            if (bram_addr_o !== 6'((idx % 4) * 16 + idx / 4)) begin
               mismatched++;
               $display("FAIL addr d=%0d: %h, required %h", d, bram_addr_o, 6'((idx % 4) * 16 + idx / 4));
            end
         end
         if (e_send) begin
            compared++;
            if (exp_data_o !== mem[ln*16+rnd]) begin
               mismatched++;
               $display("FAIL exp_data slot=%0d: %h, required %h", slot, exp_data_o, mem[ln*16+rnd]);
            end
         end
         if (e_val) begin
            e_w = rnd < 16 ? mem[ln*16+rnd] : sched[ln][rnd];
            compared++;
            if ({w_o, w_round_o, w_lane_o, w_lane_en_o} !== {e_w, 6'(rnd), 2'(ln), m[ln]}) begin
               mismatched++;
               $display("FAIL w slot=%0d: w=%h rnd=%0d ln=%0d le=%b, required w=%h rnd=%0d ln=%0d le=%b",
                        slot, w_o, w_round_o, w_lane_o, w_lane_en_o, e_w, rnd, ln, m[ln]);
            end
         end
         @(posedge clk); #1;
      end
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check_idle("reset_idle");
         @(posedge clk); #1;
      end
   endtask

   task automatic test_basic();
      fill_mem(1'b1);
      run_batch(4'hF, 1'b0, -1000);
   endtask

   task automatic test_lane_mask();
      fill_mem(1'b0);
      run_batch(4'b0101, 1'b0, -1000);
   endtask

   task automatic test_ignore_start();
      fill_mem(1'b0);
      run_batch(4'($urandom), 1'b1, -1000);
   endtask

   task automatic test_back_to_back();
      fill_mem(1'b0);
      run_batch(4'($urandom), 1'b0, -1000);
      run_batch(4'($urandom), 1'b1, -1000);
   endtask

   task automatic test_mid_reset();
      fill_mem(1'b0);
      run_batch(4'hF, 1'b0, 100);
      fill_mem(1'b0);
      run_batch(4'($urandom), 1'b0, -1000);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_lane_mask();
      test_ignore_start();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
